// File: rtl/alert_diff_sender.sv
// alert_diff_sender
//   Alert source-side endpoint. Turns a local alert request into the
//   differential four-phase alert handshake towards alert_handler. It also
//   answers ping requests and flags broken differential pairs.
//
// Parameters
//   AsyncOn       1: two-flop synchroniser on alert_rx_i (+2 cycles rx latency)
//                 0: alert_rx_i used directly
// Ports
//   clk_i         clock
//   rst_i         synchronous reset, active-high
//   alert_req_i   alert request; any high cycle marks an alert pending
//   alert_ack_o   1-cycle pulse when an alert handshake completes
//   ping_ok_o     1-cycle pulse when a ping has been answered
//   integ_fail_o  high while an rx differential pair is invalid (1-cycle lag)
//   busy_o        high whenever the FSM is not idle
//   alert_rx_i    {ping_p, ping_n, ack_p, ack_n} from alert_handler
//   alert_tx_o    {alert_p, alert_n} to alert_handler
module alert_diff_sender #(
    parameter bit AsyncOn = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       alert_req_i,
    output logic       alert_ack_o,
    output logic       ping_ok_o,
    output logic       integ_fail_o,
    output logic       busy_o,
    input  logic [3:0] alert_rx_i,
    output logic [1:0] alert_tx_o
);

    // Idle level of the rx pairs: ping_p=0/ping_n=1, ack_p=0/ack_n=1.
    localparam logic [3:0] RX_IDLE = 4'b0101;
    localparam logic [1:0] TX_IDLE = 2'b01;
    localparam logic [1:0] TX_ALRT = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HS1,
        ST_HS2,
        ST_PAUSE0,
        ST_PAUSE1,
        ST_SIGINT
    } state_e;

    state_e     r_state;
    state_e     w_state_nxt;
    logic [1:0] r_tx;
    logic [1:0] w_tx_nxt;
    logic       r_alert_pend;
    logic       r_ping_pend;
    logic       r_ping_p_q;
    logic       r_served_alert;
    logic       r_served_ping;
    logic       w_served_alert_nxt;
    logic       w_served_ping_nxt;
    logic       r_ack;
    logic       r_ping_ok;
    logic       r_integ;
    logic       r_busy;
    logic       w_ack_nxt;
    logic       w_ping_ok_nxt;
    logic       w_alert_clr;
    logic       w_alert_restore;
    logic       w_ping_clr;

    logic [3:0] w_rx;
    logic       w_ping_p;
    logic       w_ping_n;
    logic       w_ack_p;
    logic       w_ack_n;
    logic       w_integ_err;
    logic       w_ping_evt;

    generate
        if (AsyncOn) begin : g_sync
            logic [3:0] r_rx_s1;
            logic [3:0] r_rx_s2;
            // Synchroniser resets to the idle pair levels so that leaving
            // reset never looks like an integrity error.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_rx_s1 <= RX_IDLE;
                    r_rx_s2 <= RX_IDLE;
                end else begin
                    r_rx_s1 <= alert_rx_i;
                    r_rx_s2 <= r_rx_s1;
                end
            end
            assign w_rx = r_rx_s2;
        end else begin : g_direct
            assign w_rx = alert_rx_i;
        end
    endgenerate

    assign w_ping_p    = w_rx[3];
    assign w_ping_n    = w_rx[2];
    assign w_ack_p     = w_rx[1];
    assign w_ack_n     = w_rx[0];
    assign w_integ_err = (w_ack_p == w_ack_n) | (w_ping_p == w_ping_n);
    // A ping is a level change on a valid ping pair.
    assign w_ping_evt  = (w_ping_p != r_ping_p_q) & (w_ping_n == ~w_ping_p);

    always_comb begin
        w_state_nxt        = r_state;
        w_tx_nxt           = r_tx;
        w_served_alert_nxt = r_served_alert;
        w_served_ping_nxt  = r_served_ping;
        w_ack_nxt          = 1'b0;
        w_ping_ok_nxt      = 1'b0;
        w_alert_clr        = 1'b0;
        w_alert_restore    = 1'b0;
        w_ping_clr         = 1'b0;

        if (w_integ_err) begin
            w_state_nxt = ST_SIGINT;
            w_tx_nxt    = (r_state == ST_SIGINT && r_tx == 2'b11) ? 2'b00 : 2'b11;
            // An aborted handshake hands its alert back to the pending flag
            // so it is re-sent once the pairs recover.
            if (r_state == ST_HS1 || r_state == ST_HS2) begin
                w_alert_restore = r_served_alert;
            end
            w_served_alert_nxt = 1'b0;
            w_served_ping_nxt  = 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_tx_nxt = TX_IDLE;
                    if (r_alert_pend | r_ping_pend) begin
                        w_state_nxt        = ST_HS1;
                        w_tx_nxt           = TX_ALRT;
                        w_alert_clr        = 1'b1;
                        w_served_alert_nxt = r_alert_pend;
                        w_served_ping_nxt  = r_ping_pend;
                    end
                end
                ST_HS1: begin
                    w_tx_nxt          = TX_ALRT;
                    // Pings showing up before the ack are folded into this handshake.
                    w_served_ping_nxt = r_served_ping | r_ping_pend | w_ping_evt;
                    if (w_ack_p) begin
                        w_state_nxt = ST_HS2;
                        w_tx_nxt    = TX_IDLE;
                    end
                end
                ST_HS2: begin
                    w_tx_nxt = TX_IDLE;
                    if (!w_ack_p) begin
                        w_state_nxt        = ST_PAUSE0;
                        w_ack_nxt          = r_served_alert;
                        w_ping_ok_nxt      = r_served_ping;
                        w_ping_clr         = r_served_ping;
                        w_served_alert_nxt = 1'b0;
                        w_served_ping_nxt  = 1'b0;
                    end
                end
                ST_PAUSE0: begin
                    w_state_nxt = ST_PAUSE1;
                    w_tx_nxt    = TX_IDLE;
                end
                ST_PAUSE1: begin
                    w_state_nxt = ST_IDLE;
                    w_tx_nxt    = TX_IDLE;
                end
                ST_SIGINT: begin
                    w_state_nxt = ST_PAUSE0;
                    w_tx_nxt    = TX_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_tx_nxt    = TX_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= ST_IDLE;
            r_tx           <= TX_IDLE;
            r_alert_pend   <= 1'b0;
            r_ping_pend    <= 1'b0;
            r_ping_p_q     <= 1'b0;
            r_served_alert <= 1'b0;
            r_served_ping  <= 1'b0;
            r_ack          <= 1'b0;
            r_ping_ok      <= 1'b0;
            r_integ        <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_tx           <= w_tx_nxt;
            // New requests/pings win over a same-cycle clear.
            r_alert_pend   <= (r_alert_pend & ~w_alert_clr) | alert_req_i | w_alert_restore;
            r_ping_pend    <= (r_ping_pend & ~w_ping_clr) | w_ping_evt;
            r_ping_p_q     <= w_ping_p;
            r_served_alert <= w_served_alert_nxt;
            r_served_ping  <= w_served_ping_nxt;
            r_ack          <= w_ack_nxt;
            r_ping_ok      <= w_ping_ok_nxt;
            r_integ        <= w_integ_err;
            r_busy         <= (w_state_nxt != ST_IDLE);
        end
    end

    assign alert_tx_o   = r_tx;
    assign alert_ack_o  = r_ack;
    assign ping_ok_o    = r_ping_ok;
    assign integ_fail_o = r_integ;
    assign busy_o       = r_busy;

endmodule

// File: tb/tb_alert_diff_sender.sv
// Testbench for alert_diff_sender: one direct-rx instance driven from a
// per-cycle vector table plus a long-request sequence, and one synchronised
// instance checked for the added rx latency.
module tb_alert_diff_sender;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: AsyncOn = 0
    logic       rst0, req0, ack0, pok0, integ0, busy0;
    logic [3:0] rx0;
    logic [1:0] tx0;
    // Instance 1: AsyncOn = 1
    logic       rst1, req1, ack1, pok1, integ1, busy1;
    logic [3:0] rx1;
    logic [1:0] tx1;

    alert_diff_sender #(.AsyncOn(1'b0)) u_dut0 (
        .clk_i(clk), .rst_i(rst0), .alert_req_i(req0), .alert_ack_o(ack0),
        .ping_ok_o(pok0), .integ_fail_o(integ0), .busy_o(busy0),
        .alert_rx_i(rx0), .alert_tx_o(tx0)
    );

    alert_diff_sender #(.AsyncOn(1'b1)) u_dut1 (
        .clk_i(clk), .rst_i(rst1), .alert_req_i(req1), .alert_ack_o(ack1),
        .ping_ok_o(pok1), .integ_fail_o(integ1), .busy_o(busy1),
        .alert_rx_i(rx1), .alert_tx_o(tx1)
    );

    typedef struct {
        logic       rst;
        logic       req;
        logic [3:0] rx;
        logic [1:0] tx;
        logic       ack;
        logic       pok;
        logic       integ;
        logic       busy;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic add(input logic rst, input logic req, input logic [3:0] rx,
                       input logic [1:0] tx, input logic ack, input logic pok,
                       input logic integ, input logic busy);
        vec_t v;
        v.rst = rst; v.req = req; v.rx = rx; v.tx = tx;
        v.ack = ack; v.pok = pok; v.integ = integ; v.busy = busy;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    initial begin
        int p_ack, n_hs, acks, poks, cyc_resp;
        logic rack;

        rst0 = 1'b1; req0 = 1'b0; rx0 = 4'b0101;
        rst1 = 1'b1; req1 = 1'b0; rx1 = 4'b0101;

        // rx = {ping_p, ping_n, ack_p, ack_n}; expected after the edge:
        //    rst req rx       tx    ack pok int busy
        // Single alert, ack 3 cycles after tx=10, dropped 3 cycles after tx=01
        add(1, 0, 4'b0101, 2'b01, 0, 0, 0, 0);
        add(0, 1, 4'b0101, 2'b01, 0, 0, 0, 0);
        add(0, 0, 4'b0101, 2'b10, 0, 0, 0, 1);
        add(0, 0, 4'b0101, 2'b10, 0, 0, 0, 1);
        add(0, 0, 4'b0101, 2'b10, 0, 0, 0, 1);
        add(0, 0, 4'b0110, 2'b01, 0, 0, 0, 1);
        add(0, 0, 4'b0110, 2'b01, 0, 0, 0, 1);
        add(0, 0, 4'b0110, 2'b01, 0, 0, 0, 1);
        add(0, 0, 4'b0101, 2'b01, 1, 0, 0, 1);
        add(0, 0, 4'b0101, 2'b01, 0, 0, 0, 1);
        add(0, 0, 4'b0101, 2'b01, 0, 0, 0, 0);
        add(0, 0, 4'b0101, 2'b01, 0, 0, 0, 0);
        // Ping 01->10 in IDLE
        add(0, 0, 4'b1001, 2'b01, 0, 0, 0, 0);
        add(0, 0, 4'b1001, 2'b10, 0, 0, 0, 1);
        add(0, 0, 4'b1010, 2'b01, 0, 0, 0, 1);
        add(0, 0, 4'b1001, 2'b01, 0, 1, 0, 1);
        add(0, 0, 4'b1001, 2'b01, 0, 0, 0, 1);
        add(0, 0, 4'b1001, 2'b01, 0, 0, 0, 0);
        // Ping 10->01 together with an alert request
        add(0, 1, 4'b0101, 2'b01, 0, 0, 0, 0);
        add(0, 0, 4'b0101, 2'b10, 0, 0, 0, 1);
        add(0, 0, 4'b0110, 2'b01, 0, 0, 0, 1);
        add(0, 0, 4'b0101, 2'b01, 1, 1, 0, 1);
        add(0, 0, 4'b0101, 2'b01, 0, 0, 0, 1);
        add(0, 0, 4'b0101, 2'b01, 0, 0, 0, 0);
        // ack pair broken for 4 cycles during HS1, alert re-sent afterwards
        add(0, 1, 4'b0101, 2'b01, 0, 0, 0, 0);
        add(0, 0, 4'b0101, 2'b10, 0, 0, 0, 1);
        add(0, 0, 4'b0111, 2'b11, 0, 0, 1, 1);
        add(0, 0, 4'b0111, 2'b00, 0, 0, 1, 1);
        add(0, 0, 4'b0111, 2'b11, 0, 0, 1, 1);
        add(0, 0, 4'b0111, 2'b00, 0, 0, 1, 1);
        add(0, 0, 4'b0101, 2'b01, 0, 0, 0, 1);
        add(0, 0, 4'b0101, 2'b01, 0, 0, 0, 1);
        add(0, 0, 4'b0101, 2'b01, 0, 0, 0, 0);
        add(0, 0, 4'b0101, 2'b10, 0, 0, 0, 1);
        add(0, 0, 4'b0110, 2'b01, 0, 0, 0, 1);
        add(0, 0, 4'b0101, 2'b01, 1, 0, 0, 1);
        add(0, 0, 4'b0101, 2'b01, 0, 0, 0, 1);
        add(0, 0, 4'b0101, 2'b01, 0, 0, 0, 0);
        // Reset during HS1 discards the alert
        add(0, 1, 4'b0101, 2'b01, 0, 0, 0, 0);
        add(0, 0, 4'b0101, 2'b10, 0, 0, 0, 1);
        add(1, 0, 4'b0101, 2'b01, 0, 0, 0, 0);
        add(0, 0, 4'b0101, 2'b01, 0, 0, 0, 0);
        add(0, 0, 4'b0101, 2'b01, 0, 0, 0, 0);
        // Ping pair broken for one cycle in IDLE
        add(0, 0, 4'b0001, 2'b11, 0, 0, 1, 1);
        add(0, 0, 4'b0101, 2'b01, 0, 0, 0, 1);
        add(0, 0, 4'b0101, 2'b01, 0, 0, 0, 1);
        add(0, 0, 4'b0101, 2'b01, 0, 0, 0, 0);
        // Ping arriving in HS2 waits for its own handshake
        add(0, 1, 4'b0101, 2'b01, 0, 0, 0, 0);
        add(0, 0, 4'b0101, 2'b10, 0, 0, 0, 1);
        add(0, 0, 4'b0110, 2'b01, 0, 0, 0, 1);
        add(0, 0, 4'b1010, 2'b01, 0, 0, 0, 1);
        add(0, 0, 4'b1001, 2'b01, 1, 0, 0, 1);
        add(0, 0, 4'b1001, 2'b01, 0, 0, 0, 1);
        add(0, 0, 4'b1001, 2'b01, 0, 0, 0, 0);
        add(0, 0, 4'b1001, 2'b10, 0, 0, 0, 1);
        add(0, 0, 4'b1010, 2'b01, 0, 0, 0, 1);
        add(0, 0, 4'b1001, 2'b01, 0, 1, 0, 1);
        add(0, 0, 4'b1001, 2'b01, 0, 0, 0, 1);
        add(0, 0, 4'b1001, 2'b01, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst0 = vecs[i].rst;
            req0 = vecs[i].req;
            rx0  = vecs[i].rx;
            step();
            chk($sformatf("vec%0d {tx,ack,pok,integ,busy}", i),
                {26'd0, tx0, ack0, pok0, integ0, busy0},
                {26'd0, vecs[i].tx, vecs[i].ack, vecs[i].pok, vecs[i].integ, vecs[i].busy});
        end

        // Request held 20 cycles; responder acks after 8 cycles of tx=10 and
        // drops after 8 cycles of tx=01. Each handshake spans 19 edges, so the
        // request ends before the second one starts: exactly two alerts.
        // ping_p stays 1 (last table state) so no ping is generated.
        rack = 1'b0; cyc_resp = 0; acks = 0; poks = 0; p_ack = -1; n_hs = -1;
        rx0 = 4'b1001;
        for (int c = 0; c < 60; c++) begin
            req0 = (c < 20);
            rx0  = {2'b10, rack, ~rack};
            step();
            if (ack0) begin
                acks++;
                if (p_ack < 0) p_ack = c;
            end
            if (pok0) poks++;
            if (p_ack >= 0 && n_hs < 0 && tx0 == 2'b10) n_hs = c;
            if (!rack && tx0 == 2'b10) begin
                if (cyc_resp == 7) begin rack = 1'b1; cyc_resp = 0; end
                else cyc_resp++;
            end else if (rack && tx0 == 2'b01) begin
                if (cyc_resp == 7) begin rack = 1'b0; cyc_resp = 0; end
                else cyc_resp++;
            end else begin
                cyc_resp = 0;
            end
        end
        chk("held_req ack pulses", acks, 2);
        chk("held_req ping_ok pulses", poks, 0);
        chk("held_req tx=01 gap", n_hs - p_ack, 3);
        chk("held_req busy at end", busy0, 0);

        // Synchronised instance: ack response delayed by two extra edges
        rst1 = 1'b1; rx1 = 4'b0101;
        step();
        chk("async reset tx", tx1, 2'b01);
        rst1 = 1'b0; req1 = 1'b1;
        step();
        chk("async integ after reset", integ1, 0);
        req1 = 1'b0;
        step();
        chk("async tx after req", tx1, 2'b10);
        rx1 = 4'b0110;
        step();
        chk("async ack edge k", tx1, 2'b10);
        step();
        chk("async ack edge k+1", tx1, 2'b10);
        step();
        chk("async ack edge k+2", tx1, 2'b01);
        rx1 = 4'b0101;
        step();
        chk("async drop edge m", ack1, 0);
        step();
        chk("async drop edge m+1", ack1, 0);
        step();
        chk("async drop edge m+2", {ack1, pok1}, 2'b10);
        step();
        chk("async pause1", {ack1, busy1}, 2'b01);
        step();
        chk("async idle", busy1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
